// File: rtl/instr_fetch_pkg.sv
// Shared types, field positions and target helpers for the fetch front end.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions used for target computation
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int JIDX_MSB = 25;
  localparam int JIDX_LSB = 0;

  // Issue FSM: IDLE = nothing outstanding, WAIT = one request outstanding,
  // WAIT_DISCARD = one request outstanding whose word must be dropped.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT         = 2'd1,
    ST_WAIT_DISCARD = 2'd2
  } fetch_state_t;

  // One prefetch queue entry
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Conditional branch: pc+4 plus sign-extended word offset
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] word);
    return pc_plus4 + {{14{word[IMM_MSB]}}, word[IMM_MSB:IMM_LSB], 2'b00};
  endfunction

  // j/jal: region bits of pc+4 concatenated with the word index
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] word);
    return {pc_plus4[31:28], word[JIDX_MSB:JIDX_LSB], 2'b00};
  endfunction

  // jr/jalr: register value forced to word alignment
  function automatic logic [31:0] jump_reg_target(input logic [31:0] rs);
    return rs & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// Two-entry FIFO of {pc, instr}. Flush has priority over push/pop.
// Head reads as zero while empty.
module instr_fetch_buffer
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  // Storage, pointers and occupancy; push+pop on a full queue keeps count at 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head entry, zeroed when nothing is held
  always_comb begin
    head = '0;
    if (count != 2'd0) begin
      head = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: owns the PC, issues word fetches over req/ack, buffers
// up to two words and presents {pc, instr} to decode.
//
// Handshakes:
//   imem: imem_req is raised with a stable imem_addr and held until the cycle
//         imem_ack is high (ack may come in the very cycle req rises); a
//         request is never withdrawn, so a redirect marks it for discard.
//   decode: an entry transfers in a cycle where instr_valid & instr_ready;
//         branch_en/jump_en/jump_reg_en only count in such a cycle.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        instr_ready,
  input  logic        branch_en,
  input  logic        jump_en,
  input  logic        jump_reg_en,
  input  logic [31:0] rs_data
);

  localparam logic [1:0] DEPTH_L = 2'(BUF_DEPTH);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_pc_n;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic [1:0]   count;
  logic [1:0]   count_n;
  logic         fire;
  logic         redirect;
  logic         got_ack;
  logic         push;
  logic         issue;
  fetch_entry_t head;
  fetch_entry_t push_data;

  assign instr_valid = (count != 2'd0);
  assign instr       = head.instr;
  assign pc          = head.pc;

  assign fire     = instr_valid & instr_ready;
  assign redirect = fire & (jump_reg_en | jump_en | branch_en);
  assign pc_plus4 = pc + 32'd4;

  // An ack only means something while a request is outstanding; the word is
  // kept only if it is not marked for discard and no redirect squashes it.
  assign got_ack   = imem_ack & (state != ST_IDLE);
  assign push      = got_ack & (state == ST_WAIT) & ~redirect;
  assign push_data = {imem_addr, imem_rdata};

  // Redirect target, jump_reg over jump over branch
  always_comb begin
    target = branch_target(pc_plus4, instr);
    if (jump_reg_en) begin
      target = jump_reg_target(rs_data);
    end else if (jump_en) begin
      target = jump_target(pc_plus4, instr);
    end
  end

  // Occupancy and fetch address as they will be after this cycle
  always_comb begin
    count_n    = count + {1'b0, push} - {1'b0, fire};
    fetch_pc_n = fetch_pc;
    if (redirect) begin
      count_n    = 2'd0;
      fetch_pc_n = target;
    end else if (push) begin
      fetch_pc_n = fetch_pc + 32'd4;
    end
  end

  // A new request may start when the slot is free (idle, or the outstanding
  // one completes now) and the queue will still have room for its word.
  assign issue = ((state == ST_IDLE) | got_ack) & (count_n < DEPTH_L);

  // Issue FSM with registered request outputs and fetch PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      fetch_pc <= fetch_pc_n;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state     <= ST_WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc_n;
          end
        end
        ST_WAIT, ST_WAIT_DISCARD: begin
          if (got_ack) begin
            if (issue) begin
              state     <= ST_WAIT;
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc_n;
            end else begin
              state    <= ST_IDLE;
              imem_req <= 1'b0;
            end
          end else if (redirect) begin
            state <= ST_WAIT_DISCARD;
          end
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  instr_fetch_buffer u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (fire),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder, decode model and scoreboards.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;
  logic        branch_en;
  logic        jump_en;
  logic        jump_reg_en;
  logic [31:0] rs_data;

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .instr_ready (instr_ready),
    .branch_en   (branch_en),
    .jump_en     (jump_en),
    .jump_reg_en (jump_reg_en),
    .rs_data     (rs_data)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboards: presented {pc, instr} and acked request addresses
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] mem_ovr [logic [31:0]];

  // Memory responder configuration/state
  int          ack_delay;
  logic [31:0] slow_addr;
  int          slow_delay;
  bit          rand_ack;
  int          cur_delay;
  int          wait_cnt;
  bit          prev_pending;
  logic [31:0] prev_addr;
  int          ack_count;

  // Decode model configuration/state
  bit          ready_en;
  bit          rand_ready;
  logic [31:0] rule_pc [4];
  int          rule_kind [4];   // 1 branch, 2 jump, 3 jump_reg
  logic [31:0] rule_rs [4];
  bit          rule_armed [4];
  int          cyc;
  int          first_fire_cyc;
  int          last_fire_cyc;
  int          redir_cyc;
  int          post_cyc;
  bit          post_pending;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0C3C};
  endfunction

  // Memory responder and decode model, both acting at the falling edge
  initial begin : monitor
    logic [63:0] e;
    logic [31:0] ea;
    bit          fire;
    int          hit;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    branch_en = 1'b0; jump_en = 1'b0; jump_reg_en = 1'b0; rs_data = '0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        imem_ack = 1'b0; prev_pending = 0; wait_cnt = 0; instr_ready = 1'b0;
        branch_en = 1'b0; jump_en = 1'b0; jump_reg_en = 1'b0;
        continue;
      end
      // memory side
      if (prev_pending) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL addr_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, prev_addr);
        end
      end
      if (imem_req) begin
        if (!prev_pending) begin
          wait_cnt  = 0;
          cur_delay = rand_ack ? int'($urandom_range(0, 3)) :
                      ((imem_addr == slow_addr) ? slow_delay : ack_delay);
        end
        if (wait_cnt >= cur_delay) begin
          imem_ack     = 1'b1;
          imem_rdata   = mem_word(imem_addr);
          ack_count++;
          prev_pending = 0;
          if (exp_addr_q.size() > 0) begin
            ea = exp_addr_q.pop_front();
            n_checks++;
            if (imem_addr !== ea) begin
              n_fail++;
              $display("FAIL imem_addr: got %h, required %h", imem_addr, ea);
            end
          end
        end else begin
          imem_ack     = 1'b0;
          imem_rdata   = 32'hDEAD_BEEF;
          wait_cnt++;
          prev_pending = 1;
          prev_addr    = imem_addr;
        end
      end else begin
        imem_ack     = 1'b0;
        imem_rdata   = 32'hDEAD_BEEF;
        prev_pending = 0;
      end
      // decode side
      instr_ready = (exp_q.size() > 0) &&
                    (rand_ready ? ($urandom_range(0, 1) == 1) : ready_en);
      fire = instr_valid && instr_ready;
      if (fire) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({pc, instr} !== e) begin
          n_fail++;
          $display("FAIL fetch_out: got pc=%h instr=%h, required pc=%h instr=%h", pc, instr, e[63:32], e[31:0]);
        end
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
        last_fire_cyc = cyc;
        if (post_pending) begin
          post_cyc     = cyc;
          post_pending = 0;
        end
        hit = -1;
        for (int i = 0; i < 4; i++) begin
          if (hit < 0 && rule_armed[i] && rule_pc[i] == pc) hit = i;
        end
        branch_en = 1'b0; jump_en = 1'b0; jump_reg_en = 1'b0; rs_data = $urandom;
        if (hit >= 0) begin
          // lower-priority enables are raised too so priority is exercised
          branch_en   = 1'b1;
          jump_en     = (rule_kind[hit] >= 2);
          jump_reg_en = (rule_kind[hit] == 3);
          if (rule_kind[hit] == 3) rs_data = rule_rs[hit];
          rule_armed[hit] = 0;
          redir_cyc       = cyc;
          post_pending    = 1;
        end
      end else begin
        // enables are don't-care without a transfer
        branch_en   = ($urandom_range(0, 1) == 1);
        jump_en     = ($urandom_range(0, 1) == 1);
        jump_reg_en = ($urandom_range(0, 1) == 1);
        rs_data     = $urandom;
      end
    end
  end

  // Driver tasks
  task automatic clear_config();
    ready_en = 0; rand_ready = 0; rand_ack = 0; ack_delay = 0;
    slow_addr = 32'hFFFF_FFFF; slow_delay = 0; ack_count = 0;
    for (int i = 0; i < 4; i++) rule_armed[i] = 0;
    exp_q.delete(); exp_addr_q.delete(); mem_ovr.delete();
    first_fire_cyc = -1; last_fire_cyc = -1; redir_cyc = 0; post_cyc = 0; post_pending = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_config();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({start + 32'(4 * i), mem_word(start + 32'(4 * i))});
    end
  endtask

  task automatic set_rule(input int i, input logic [31:0] rpc, input int kind, input logic [31:0] rs);
    rule_pc[i] = rpc; rule_kind[i] = kind; rule_rs[i] = rs; rule_armed[i] = 1;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d words not presented, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (exp_addr_q.size() > 0) begin
      n_fail++;
      $display("FAIL %s addr_left: %0d requests not seen, required 0", name, exp_addr_q.size());
      exp_addr_q.delete();
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, required 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h, required 00000000", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h, required 00000000", instr); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h, required 00000000", pc); end
    @(posedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h, required req=1 addr=00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_seq(32'h0, 8);
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(32'(4 * i));
    ready_en = 1;
    drain(60, "back_to_back");
    n_checks++;
    if (last_fire_cyc - first_fire_cyc + 1 != 8) begin
      n_fail++; $display("FAIL stream_rate: 8 words over %0d cycles, required 8", last_fire_cyc - first_fire_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_seq(32'h0, 4);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'(4 * i));
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b, required 0", imem_req); end
    n_checks++; if (ack_count != 2) begin n_fail++; $display("FAIL full_acks: got %0d, required 2", ack_count); end
    n_checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h0) begin
      n_fail++; $display("FAIL full_head: got valid=%b pc=%h, required valid=1 pc=00000000", instr_valid, pc);
    end
    ready_en = 1;
    drain(60, "backpressure");
  endtask

  task automatic test_branch();
    do_reset();
    mem_ovr[32'h100] = 32'h1000_FFFE;
    set_rule(0, 32'h100, 1, 32'h0);
    push_seq(32'h0, 65);
    exp_q.push_back({32'h0FC, mem_word(32'h0FC)});
    exp_q.push_back({32'h100, mem_word(32'h100)});
    exp_q.push_back({32'h104, mem_word(32'h104)});
    ready_en = 1;
    drain(300, "branch");
    n_checks++;
    if (post_cyc - redir_cyc != 2) begin
      n_fail++; $display("FAIL branch_latency: got %0d cycles, required 2", post_cyc - redir_cyc);
    end
  endtask

  task automatic test_jump();
    do_reset();
    mem_ovr[32'h0040_0010] = 32'h0800_0040;
    set_rule(0, 32'h0, 3, 32'h0040_0010);
    set_rule(1, 32'h0040_0010, 2, 32'h0);
    exp_q.push_back({32'h0, mem_word(32'h0)});
    push_seq(32'h0040_0010, 1);
    push_seq(32'h0000_0100, 2);
    ready_en = 1;
    drain(60, "jump");
    n_checks++;
    if (post_cyc - redir_cyc != 2) begin
      n_fail++; $display("FAIL jump_latency: got %0d cycles, required 2", post_cyc - redir_cyc);
    end
  endtask

  task automatic test_jr_outstanding();
    do_reset();
    slow_addr  = 32'h10;
    slow_delay = 3;
    set_rule(0, 32'hC, 3, 32'h2003);
    push_seq(32'h0, 4);
    push_seq(32'h2000, 2);
    for (int i = 0; i < 5; i++) exp_addr_q.push_back(32'(4 * i));
    exp_addr_q.push_back(32'h2000);
    exp_addr_q.push_back(32'h2004);
    ready_en = 1;
    drain(60, "jr_outstanding");
    n_checks++;
    if (post_cyc - redir_cyc != 5) begin
      n_fail++; $display("FAIL jr_latency: got %0d cycles, required 5", post_cyc - redir_cyc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_rule(0, 32'h0, 3, 32'hFFFF_FFF8);
    exp_q.push_back({32'h0, mem_word(32'h0)});
    push_seq(32'hFFFF_FFF8, 2);
    push_seq(32'h0, 2);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'hFFFF_FFF8);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    ready_en = 1;
    drain(60, "wrap");
  endtask

  task automatic test_reset_mid();
    do_reset();
    slow_addr  = 32'h4;
    slow_delay = 1000;
    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got req=%b addr=%h valid=%b, required 1 00000004 1", imem_req, imem_addr, instr_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_req: got req=%b addr=%h, required 0 00000000", imem_req, imem_addr);
    end
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_out: got valid=%b instr=%h pc=%h, required 0 0 0", instr_valid, instr, pc);
    end
    repeat (2) @(posedge clk);
    slow_addr = 32'hFFFF_FFFF;
    push_seq(32'h0, 2);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    ready_en = 1;
    #2 rst_n = 1'b1;
    drain(60, "reset_mid");
  endtask

  task automatic test_random();
    do_reset();
    rand_ack   = 1;
    rand_ready = 1;
    push_seq(32'h0, 40);
    drain(800, "random");
  endtask

  // Sequence and report
  initial begin : main
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_branch();
    test_jump();
    test_jr_outstanding();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
